apu_ch1_ctrl: RTL and testbench

Synchronous controller that sequences APU channel 1.
- Contains the 512 Hz frame sequencer, which produces the length, sweep and envelope tick strobes.
- Contains the NR14 trigger state machine, which generates the ch1_restart pulse.
- Contains the 6-bit length counter and the ch1_active status flag.
- Sits between the register file (NR11/NR12/NR14 write strobes, DIV tap) and the channel 1 datapath (sweep, envelope, duty) that consumes its strobes.

---
 rtl/apu_pkg.sv | 18 +
 rtl/apu_frame_seq.sv | 41 ++++
 rtl/apu_ch1_ctrl.sv | 122 ++++++++++++
 tb/tb_apu_ch1_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared types and constants for the APU channel 1 controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apu_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RESTART = 1'b1
  } ch1_trig_state_t;

  // Bit n set means the strobe fires when the sequencer leaves step n.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

  localparam int LEN_BITS_DEFAULT = 6;

endpackage

// File: rtl/apu_frame_seq.sv
// 512 Hz frame sequencer: DIV falling-edge detect, 8-step counter, strobe decode.
// Latency: strobes and the new step appear one cycle after the div_tap fall is seen.
// Backpressure: none; strobes are one-cycle pulses the consumer must take.
module apu_frame_seq
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_on,
  input  logic       div_tap,
  output logic [2:0] frame_step,
  output logic       len_clk,
  output logic       sweep_clk,
  output logic       env_clk
);

  logic div_prev;
  logic div_fall;

  assign div_fall = div_prev & ~div_tap;

  // Edge detect, step advance and strobes decoded from the step being left.
  always_ff @(posedge clk) begin
    if (reset || !apu_on) begin
      div_prev   <= 1'b0;
      frame_step <= 3'd0;
      len_clk    <= 1'b0;
      sweep_clk  <= 1'b0;
      env_clk    <= 1'b0;
    end else begin
      div_prev  <= div_tap;
      len_clk   <= div_fall & LEN_STEPS[frame_step];
      sweep_clk <= div_fall & SWEEP_STEPS[frame_step];
      env_clk   <= div_fall & ENV_STEPS[frame_step];
      if (div_fall) begin
        frame_step <= frame_step + 3'd1;
      end
    end
  end

endmodule

// File: rtl/apu_ch1_ctrl.sv
// Channel 1 sequencing: frame sequencer, NR14 trigger FSM, length counter, active flag.
// Latency: restart pulse starts the cycle after the NR14 write; active settles as the pulse ends.
// Backpressure: none; write strobes are accepted every cycle.
module apu_ch1_ctrl
  import apu_pkg::*;
#(
  parameter int RESTART_CYCLES = 2,
  parameter int LEN_BITS       = LEN_BITS_DEFAULT
) (
  input  logic                dyfa_1mhz,
  input  logic                apu_reset,
  input  logic                apu_on,
  input  logic                div_tap,
  input  logic [7:0]          d,
  input  logic                wr_nr11,
  input  logic                wr_nr14,
  input  logic                dac_en,
  input  logic                sweep_ovf,
  output logic                ch1_restart,
  output logic                len_clk,
  output logic                sweep_clk,
  output logic                env_clk,
  output logic [2:0]          frame_step,
  output logic                ch1_active,
  output logic [LEN_BITS-1:0] len_cnt
);

  localparam logic [2:0] RCNT_LOAD = 3'(RESTART_CYCLES);

  ch1_trig_state_t state;
  logic [2:0]      rcnt;
  logic            len_en;
  logic            len_expired;
  logic            trig;
  logic            len_tick;
  logic            len_wrap;
  logic            expire_kill;
  logic            fsm_exit;

  apu_frame_seq u_frame_seq (
    .clk        (dyfa_1mhz),
    .reset      (apu_reset),
    .apu_on     (apu_on),
    .div_tap    (div_tap),
    .frame_step (frame_step),
    .len_clk    (len_clk),
    .sweep_clk  (sweep_clk),
    .env_clk    (env_clk)
  );

  assign trig     = wr_nr14 & d[7] & apu_on;
  // Once expired the counter parks at 0 until a trigger or NR11 write.
  assign len_tick = len_clk & len_en & ~len_expired;
  assign len_wrap = len_tick & (len_cnt == '1);
  // A same-cycle NR11 write drops the tick; a same-cycle trigger reloads instead.
  assign expire_kill = len_wrap & ~wr_nr11 & ~trig;
  assign fsm_exit    = (state == RESTART) & ~trig & (rcnt == 3'd1);

  // Length counter: NR11 load beats a trigger reload, which beats a tick.
  always_ff @(posedge dyfa_1mhz) begin
    if (apu_reset) begin
      len_cnt     <= '0;
      len_en      <= 1'b0;
      len_expired <= 1'b0;
    end else begin
      if (!apu_on) begin
        len_en <= 1'b0;
      end else if (wr_nr14) begin
        len_en <= d[6];
      end
      if (wr_nr11) begin
        len_cnt     <= d[LEN_BITS-1:0];
        len_expired <= 1'b0;
      end else if (trig && (len_expired || len_wrap)) begin
        len_cnt     <= '0;
        len_expired <= 1'b0;
      end else if (len_tick) begin
        len_cnt <= len_cnt + 1'b1;
        if (len_cnt == '1) begin
          len_expired <= 1'b1;
        end
      end
    end
  end

  // Trigger FSM with registered restart pulse and channel-active flag.
  always_ff @(posedge dyfa_1mhz) begin
    if (apu_reset || !apu_on) begin
      state       <= IDLE;
      rcnt        <= 3'd0;
      ch1_restart <= 1'b0;
      ch1_active  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state       <= RESTART;
            rcnt        <= RCNT_LOAD;
            ch1_restart <= 1'b1;
          end
        end
        RESTART: begin
          if (trig) begin
            rcnt <= RCNT_LOAD;
          end else if (rcnt == 3'd1) begin
            state       <= IDLE;
            ch1_restart <= 1'b0;
          end else begin
            rcnt <= rcnt - 3'd1;
          end
        end
      endcase
      // Kills win; the exit only raises active when the DAC is powered.
      if (!dac_en || sweep_ovf || expire_kill) begin
        ch1_active <= 1'b0;
      end else if (fsm_exit) begin
        ch1_active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apu_ch1_ctrl.sv
// Directed bench for apu_ch1_ctrl: sequencer strobes, trigger pulse, length, kills, power.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: n/a.
module tb_apu_ch1_ctrl;

  logic       dyfa_1mhz = 1'b0;
  logic       apu_reset = 1'b1;
  logic       apu_on    = 1'b0;
  logic       div_tap   = 1'b0;
  logic [7:0] d         = 8'h00;
  logic       wr_nr11   = 1'b0;
  logic       wr_nr14   = 1'b0;
  logic       dac_en    = 1'b0;
  logic       sweep_ovf = 1'b0;
  logic       ch1_restart;
  logic       len_clk;
  logic       sweep_clk;
  logic       env_clk;
  logic [2:0] frame_step;
  logic       ch1_active;
  logic [5:0] len_cnt;

  int checks = 0;
  int errors = 0;

  apu_ch1_ctrl #(.RESTART_CYCLES(2), .LEN_BITS(6)) dut (
    .dyfa_1mhz   (dyfa_1mhz),
    .apu_reset   (apu_reset),
    .apu_on      (apu_on),
    .div_tap     (div_tap),
    .d           (d),
    .wr_nr11     (wr_nr11),
    .wr_nr14     (wr_nr14),
    .dac_en      (dac_en),
    .sweep_ovf   (sweep_ovf),
    .ch1_restart (ch1_restart),
    .len_clk     (len_clk),
    .sweep_clk   (sweep_clk),
    .env_clk     (env_clk),
    .frame_step  (frame_step),
    .ch1_active  (ch1_active),
    .len_cnt     (len_cnt)
  );

  always #5 dyfa_1mhz = ~dyfa_1mhz;

  task automatic tick();
    @(posedge dyfa_1mhz);
    #1;
  endtask

  task automatic write11(input logic [7:0] v);
    d = v; wr_nr11 = 1'b1;
    tick();
    wr_nr11 = 1'b0; d = 8'h00;
  endtask

  task automatic write14(input logic [7:0] v);
    d = v; wr_nr14 = 1'b1;
    tick();
    wr_nr14 = 1'b0; d = 8'h00;
  endtask

  // One div_tap fall; returns strobes on the cycle after the edge and the cycle after that.
  task automatic fall_edge(output logic l1, output logic s1, output logic e1,
                           output logic l2, output logic s2, output logic e2);
    div_tap = 1'b1;
    tick();
    div_tap = 1'b0;
    tick();
    l1 = len_clk; s1 = sweep_clk; e1 = env_clk;
    tick();
    l2 = len_clk; s2 = sweep_clk; e2 = env_clk;
  endtask

  task automatic test_reset();
    apu_reset = 1'b1;
    tick(); tick();
    checks++;
    if ({ch1_restart, len_clk, sweep_clk, env_clk, ch1_active} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {ch1_restart, len_clk, sweep_clk, env_clk, ch1_active});
    end
    checks++;
    if (frame_step !== 3'd0) begin errors++; $display("FAIL reset_step got %0d want 0", frame_step); end
    checks++;
    if (len_cnt !== 6'd0) begin errors++; $display("FAIL reset_len got %0d want 0", len_cnt); end
    apu_reset = 1'b0;
    apu_on = 1'b1;
    tick();
  endtask

  task automatic test_frame_seq();
    logic l1, s1, e1, l2, s2, e2;
    logic [2:0] exp_step;
    for (int s = 0; s < 8; s++) begin
      exp_step = 3'((s + 1) % 8);
      fall_edge(l1, s1, e1, l2, s2, e2);
      checks++;
      if (l1 !== 1'(s % 2 == 0)) begin errors++; $display("FAIL seq_len step %0d got %b want %b", s, l1, (s % 2 == 0)); end
      checks++;
      if (s1 !== 1'(s == 2 || s == 6)) begin errors++; $display("FAIL seq_sweep step %0d got %b want %b", s, s1, (s == 2 || s == 6)); end
      checks++;
      if (e1 !== 1'(s == 7)) begin errors++; $display("FAIL seq_env step %0d got %b want %b", s, e1, (s == 7)); end
      checks++;
      if ({l2, s2, e2} !== 3'b000) begin errors++; $display("FAIL seq_width step %0d got %b want 000", s, {l2, s2, e2}); end
      checks++;
      if (frame_step !== exp_step) begin errors++; $display("FAIL seq_step got %0d want %0d", frame_step, exp_step); end
    end
  endtask

  task automatic test_trigger();
    dac_en = 1'b1;
    write14(8'h80);
    checks++;
    if (ch1_restart !== 1'b1 || ch1_active !== 1'b0) begin
      errors++; $display("FAIL trig_c1 got rs=%b act=%b want rs=1 act=0", ch1_restart, ch1_active);
    end
    tick();
    checks++;
    if (ch1_restart !== 1'b1) begin errors++; $display("FAIL trig_c2 got %b want 1", ch1_restart); end
    tick();
    checks++;
    if (ch1_restart !== 1'b0 || ch1_active !== 1'b1) begin
      errors++; $display("FAIL trig_end got rs=%b act=%b want rs=0 act=1", ch1_restart, ch1_active);
    end
  endtask

  task automatic test_length();
    logic l1, s1, e1, l2, s2, e2;
    int n;
    int guard;
    write11(8'h3E);
    checks++;
    if (len_cnt !== 6'd62) begin errors++; $display("FAIL len_load got %0d want 62", len_cnt); end
    write14(8'hC0);
    tick(); tick();
    checks++;
    if (ch1_active !== 1'b1) begin errors++; $display("FAIL len_act got %b want 1", ch1_active); end
    fall_edge(l1, s1, e1, l2, s2, e2);
    checks++;
    if (len_cnt !== 6'd63 || ch1_active !== 1'b1) begin
      errors++; $display("FAIL len_63 got cnt=%0d act=%b want cnt=63 act=1", len_cnt, ch1_active);
    end
    fall_edge(l1, s1, e1, l2, s2, e2);
    fall_edge(l1, s1, e1, l2, s2, e2);
    checks++;
    if (len_cnt !== 6'd0 || ch1_active !== 1'b0) begin
      errors++; $display("FAIL len_wrap got cnt=%0d act=%b want cnt=0 act=0", len_cnt, ch1_active);
    end
    write14(8'hC0);
    checks++;
    if (len_cnt !== 6'd0) begin errors++; $display("FAIL len_retrig got %0d want 0", len_cnt); end
    tick(); tick();
    checks++;
    if (ch1_active !== 1'b1) begin errors++; $display("FAIL len_retrig_act got %b want 1", ch1_active); end
    n = 0;
    guard = 0;
    while (n < 64 && guard < 200) begin
      fall_edge(l1, s1, e1, l2, s2, e2);
      guard++;
      if (l1) begin
        n++;
        if (n == 63) begin
          checks++;
          if (len_cnt !== 6'd63 || ch1_active !== 1'b1) begin
            errors++; $display("FAIL len_63b got cnt=%0d act=%b want cnt=63 act=1", len_cnt, ch1_active);
          end
        end
      end
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL len_ticks got %0d want 64", n); end
    checks++;
    if (len_cnt !== 6'd0 || ch1_active !== 1'b0) begin
      errors++; $display("FAIL len_full got cnt=%0d act=%b want cnt=0 act=0", len_cnt, ch1_active);
    end
  endtask

  task automatic test_kill();
    dac_en = 1'b1;
    write14(8'h80);
    tick(); tick();
    checks++;
    if (ch1_active !== 1'b1) begin errors++; $display("FAIL kill_pre got %b want 1", ch1_active); end
    dac_en = 1'b0;
    tick();
    checks++;
    if (ch1_active !== 1'b0) begin errors++; $display("FAIL kill_dac got %b want 0", ch1_active); end
    write14(8'h80);
    checks++;
    if (ch1_restart !== 1'b1) begin errors++; $display("FAIL kill_nodac_rs got %b want 1", ch1_restart); end
    tick(); tick();
    checks++;
    if (ch1_restart !== 1'b0 || ch1_active !== 1'b0) begin
      errors++; $display("FAIL kill_nodac got rs=%b act=%b want rs=0 act=0", ch1_restart, ch1_active);
    end
    dac_en = 1'b1;
    write14(8'h80);
    tick(); tick();
    checks++;
    if (ch1_active !== 1'b1) begin errors++; $display("FAIL kill_pre2 got %b want 1", ch1_active); end
    sweep_ovf = 1'b1;
    tick();
    sweep_ovf = 1'b0;
    checks++;
    if (ch1_active !== 1'b0) begin errors++; $display("FAIL kill_ovf got %b want 0", ch1_active); end
    tick();
    checks++;
    if (ch1_active !== 1'b0) begin errors++; $display("FAIL kill_ovf_hold got %b want 0", ch1_active); end
  endtask

  task automatic test_reset_mid();
    dac_en = 1'b1;
    write14(8'h80);
    checks++;
    if (ch1_restart !== 1'b1) begin errors++; $display("FAIL rmid_rs got %b want 1", ch1_restart); end
    apu_reset = 1'b1;
    tick();
    checks++;
    if ({ch1_restart, len_clk, sweep_clk, env_clk, ch1_active} !== 5'b0) begin
      errors++; $display("FAIL rmid_flags got %b want 00000", {ch1_restart, len_clk, sweep_clk, env_clk, ch1_active});
    end
    checks++;
    if (frame_step !== 3'd0 || len_cnt !== 6'd0) begin
      errors++; $display("FAIL rmid_cnt got step=%0d len=%0d want 0 0", frame_step, len_cnt);
    end
    apu_reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int hi;
    hi = 0;
    write14(8'h80);
    if (ch1_restart) hi++;
    write14(8'h80);
    if (ch1_restart) hi++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ch1_restart) hi++;
      else break;
    end
    checks++;
    if (hi !== 3) begin errors++; $display("FAIL b2b_width got %0d want 3", hi); end
    checks++;
    if (ch1_active !== 1'b1) begin errors++; $display("FAIL b2b_act got %b want 1", ch1_active); end
  endtask

  task automatic test_power_off();
    logic l1, s1, e1, l2, s2, e2;
    for (int i = 0; i < 5; i++) begin
      fall_edge(l1, s1, e1, l2, s2, e2);
    end
    checks++;
    if (frame_step !== 3'd5) begin errors++; $display("FAIL poff_step5 got %0d want 5", frame_step); end
    apu_on = 1'b0;
    tick();
    checks++;
    if (frame_step !== 3'd0 || ch1_active !== 1'b0) begin
      errors++; $display("FAIL poff_clear got step=%0d act=%b want 0 0", frame_step, ch1_active);
    end
    fall_edge(l1, s1, e1, l2, s2, e2);
    checks++;
    if ({l1, s1, e1, l2, s2, e2} !== 6'b0 || frame_step !== 3'd0) begin
      errors++; $display("FAIL poff_strobe got %b step=%0d want 0", {l1, s1, e1, l2, s2, e2}, frame_step);
    end
    write11(8'h10);
    checks++;
    if (len_cnt !== 6'd16) begin errors++; $display("FAIL poff_nr11 got %0d want 16", len_cnt); end
    write14(8'h80);
    checks++;
    if (ch1_restart !== 1'b0) begin errors++; $display("FAIL poff_trig got %b want 0", ch1_restart); end
    apu_on = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_frame_seq();
    test_trigger();
    test_length();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    test_power_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
